// File: rtl/cmp_share_arbiter_if.sv
// Request/result bundle for the shared set-less-than compare unit.
// The slave modport is the arbiter's view; master is the requesters plus result consumer.
interface cmp_share_arbiter_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 5
);
   logic              s0_valid;
   logic              s0_ready;
   logic [DATA_W-1:0] s0_op1;
   logic [DATA_W-1:0] s0_op2;
   logic [6:0]        s0_opcode;
   logic [2:0]        s0_func3;
   logic [TAG_W-1:0]  s0_tag;

   logic              s1_valid;
   logic              s1_ready;
   logic [DATA_W-1:0] s1_op1;
   logic [DATA_W-1:0] s1_op2;
   logic [6:0]        s1_opcode;
   logic [2:0]        s1_func3;
   logic [TAG_W-1:0]  s1_tag;

   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_result;
   logic              m_src;
   logic [TAG_W-1:0]  m_tag;
   logic [15:0]       conflict_cnt;

   modport master (
      output s0_valid, s0_op1, s0_op2, s0_opcode, s0_func3, s0_tag,
      output s1_valid, s1_op1, s1_op2, s1_opcode, s1_func3, s1_tag,
      output m_ready,
      input  s0_ready, s1_ready,
      input  m_valid, m_result, m_src, m_tag, conflict_cnt
   );

   modport slave (
      input  s0_valid, s0_op1, s0_op2, s0_opcode, s0_func3, s0_tag,
      input  s1_valid, s1_op1, s1_op2, s1_opcode, s1_func3, s1_tag,
      input  m_ready,
      output s0_ready, s1_ready,
      output m_valid, m_result, m_src, m_tag, conflict_cnt
   );
endinterface

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter in front of one shared SLT/SLTU compare, with a single registered
// result stage under valid/ready backpressure.
module cmp_share_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 5
) (
   input logic                clk,
   input logic                rst_n,
   cmp_share_arbiter_if.slave bus
);

   localparam logic [6:0] OpcOp    = 7'b0110011;
   localparam logic [6:0] OpcOpImm = 7'b0010011;
   localparam logic [2:0] F3Slt    = 3'b010;
   localparam logic [2:0] F3Sltu   = 3'b011;

   logic              r_m_valid;
   logic [DATA_W-1:0] r_m_result;
   logic              r_m_src;
   logic [TAG_W-1:0]  r_m_tag;
   logic [15:0]       r_conflict_cnt;
   logic              r_rr_ptr;

   logic              w_can_issue;
   logic              w_contest;
   logic              w_gnt;
   logic              w_gnt_sel;
   logic [DATA_W-1:0] w_op1;
   logic [DATA_W-1:0] w_op2;
   logic [6:0]        w_opcode;
   logic [2:0]        w_func3;
   logic [TAG_W-1:0]  w_tag;
   logic              w_is_cmp;
   logic              w_lt_s;
   logic              w_lt_u;
   logic              w_res_bit;

   assign w_can_issue = !r_m_valid || bus.m_ready;
   assign w_contest   = bus.s0_valid && bus.s1_valid && w_can_issue;

   always_comb begin
      w_gnt     = 1'b0;
      w_gnt_sel = 1'b0;
      if (w_can_issue) begin
         if (bus.s0_valid && bus.s1_valid) begin
            w_gnt     = 1'b1;
            w_gnt_sel = r_rr_ptr;
         end else if (bus.s0_valid) begin
            w_gnt     = 1'b1;
            w_gnt_sel = 1'b0;
         end else if (bus.s1_valid) begin
            w_gnt     = 1'b1;
            w_gnt_sel = 1'b1;
         end
      end
   end

   // Ready depends only on valids, m_ready and registered state, never on payload.
   assign bus.s0_ready = w_gnt && !w_gnt_sel;
   assign bus.s1_ready = w_gnt && w_gnt_sel;

   always_comb begin
      if (w_gnt_sel) begin
         w_op1    = bus.s1_op1;
         w_op2    = bus.s1_op2;
         w_opcode = bus.s1_opcode;
         w_func3  = bus.s1_func3;
         w_tag    = bus.s1_tag;
      end else begin
         w_op1    = bus.s0_op1;
         w_op2    = bus.s0_op2;
         w_opcode = bus.s0_opcode;
         w_func3  = bus.s0_func3;
         w_tag    = bus.s0_tag;
      end
   end

   assign w_is_cmp = (w_opcode == OpcOp) || (w_opcode == OpcOpImm);
   assign w_lt_s   = $signed(w_op1) < $signed(w_op2);
   assign w_lt_u   = w_op1 < w_op2;

   // Unsupported encodings still flow through and return 0.
   always_comb begin
      w_res_bit = 1'b0;
      if (w_is_cmp) begin
         case (w_func3)
            F3Slt:   w_res_bit = w_lt_s;
            F3Sltu:  w_res_bit = w_lt_u;
            default: w_res_bit = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_valid      <= 1'b0;
         r_m_result     <= '0;
         r_m_src        <= 1'b0;
         r_m_tag        <= '0;
         r_conflict_cnt <= '0;
         r_rr_ptr       <= 1'b0;
      end else begin
         if (w_gnt) begin
            r_m_valid  <= 1'b1;
            r_m_result <= DATA_W'(w_res_bit);
            r_m_src    <= w_gnt_sel;
            r_m_tag    <= w_tag;
            r_rr_ptr   <= ~w_gnt_sel;
         end else if (bus.m_ready) begin
            r_m_valid <= 1'b0;
         end
         if (w_contest && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
         end
      end
   end

   assign bus.m_valid      = r_m_valid;
   assign bus.m_result     = r_m_result;
   assign bus.m_src        = r_m_src;
   assign bus.m_tag        = r_m_tag;
   assign bus.conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench: expected results are queued at issue and popped by a monitor thread
// whenever a result handshake occurs on the output stage.
module tb_cmp_share_arbiter;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [2:0] F_SLT  = 3'b010;
   localparam logic [2:0] F_SLTU = 3'b011;
   localparam logic [2:0] F_ADD  = 3'b000;

   typedef struct packed {
      logic [31:0] res;
      logic        src;
      logic [4:0]  tag;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;
   exp_t exp_q[$];

   cmp_share_arbiter_if #(.DATA_W(32), .TAG_W(5)) bus ();

   cmp_share_arbiter #(.DATA_W(32), .TAG_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   task automatic drv(input bit sel, input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] tag);
      if (!sel) begin
         bus.s0_valid = v;  bus.s0_op1 = a;  bus.s0_op2 = b;
         bus.s0_opcode = opc;  bus.s0_func3 = f3;  bus.s0_tag = tag;
      end else begin
         bus.s1_valid = v;  bus.s1_op1 = a;  bus.s1_op2 = b;
         bus.s1_opcode = opc;  bus.s1_func3 = f3;  bus.s1_tag = tag;
      end
   endtask

   task automatic push(input logic [31:0] r, input logic s, input logic [4:0] t);
      exp_t e;
      e.res = r;
      e.src = s;
      e.tag = t;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_result: got src=%0d tag=%0d expected none",
                        bus.m_src, bus.m_tag);
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("mon_result_tag%0d", e.tag), bus.m_result, e.res);
               chk($sformatf("mon_src_tag%0d", e.tag), 32'(bus.m_src), 32'(e.src));
               chk($sformatf("mon_tag_tag%0d", e.tag), 32'(bus.m_tag), 32'(e.tag));
            end
         end
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      bus.m_ready = 1'b1;
      drv(0, 0, 0, 0, 7'd0, 3'd0, 5'd0);
      drv(1, 0, 0, 0, 7'd0, 3'd0, 5'd0);
      fork
         monitor();
      join_none

      repeat (2) @(posedge clk);
      #1;
      chk("reset_m_valid", 32'(bus.m_valid), 32'd0);
      chk("reset_m_result", bus.m_result, 32'd0);
      chk("reset_m_src", 32'(bus.m_src), 32'd0);
      chk("reset_m_tag", 32'(bus.m_tag), 32'd0);
      chk("reset_conflict_cnt", 32'(bus.conflict_cnt), 32'd0);
      rst_n = 1'b1;

      // Single request, signed SLT: -1 < 1
      drv(0, 1, 32'hFFFF_FFFF, 32'd1, OP_R, F_SLT, 5'd7);
      #1;
      chk("t1_s0_ready", 32'(bus.s0_ready), 32'd1);
      chk("t1_s1_ready", 32'(bus.s1_ready), 32'd0);
      push(32'd1, 1'b0, 5'd7);
      step();
      drv(0, 0, 0, 0, 7'd0, 3'd0, 5'd0);
      chk("t1_latency_m_valid", 32'(bus.m_valid), 32'd1);

      // Same operands unsigned, then SLTIU
      drv(1, 1, 32'hFFFF_FFFF, 32'd1, OP_R, F_SLTU, 5'd3);
      #1;
      chk("t2_sltu_s1_ready", 32'(bus.s1_ready), 32'd1);
      push(32'd0, 1'b1, 5'd3);
      step();
      drv(1, 1, 32'd0, 32'd5, OP_I, F_SLTU, 5'd4);
      #1;
      chk("t2_sltiu_s1_ready", 32'(bus.s1_ready), 32'd1);
      push(32'd1, 1'b1, 5'd4);
      step();
      drv(1, 0, 0, 0, 7'd0, 3'd0, 5'd0);

      // Contention: rr_ptr is 0 here, so order is 0,1,0,1
      drv(0, 1, 32'd5, 32'hFFFF_FFFD, OP_R, F_SLT, 5'd10);
      drv(1, 1, 32'd5, 32'hFFFF_FFFD, OP_R, F_SLTU, 5'd11);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("t3_s0_ready_%0d", i), 32'(bus.s0_ready), 32'((i % 2) == 0));
         chk($sformatf("t3_s1_ready_%0d", i), 32'(bus.s1_ready), 32'((i % 2) == 1));
         if ((i % 2) == 0) push(32'd0, 1'b0, 5'd10);
         else              push(32'd1, 1'b1, 5'd11);
         step();
      end
      drv(0, 0, 0, 0, 7'd0, 3'd0, 5'd0);
      drv(1, 0, 0, 0, 7'd0, 3'd0, 5'd0);
      chk("t3_conflict_cnt", 32'(bus.conflict_cnt), 32'd4);

      // Backpressure: hold result X (tag 12) while Y (tag 13) waits
      drv(0, 1, 32'd1, 32'd2, OP_R, F_SLT, 5'd12);
      push(32'd1, 1'b0, 5'd12);
      step();
      bus.m_ready = 1'b0;
      drv(0, 1, 32'hFFFF_FFF9, 32'hFFFF_FFF8, OP_I, F_SLT, 5'd13);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("t4_bp_s0_ready_%0d", i), 32'(bus.s0_ready), 32'd0);
         chk($sformatf("t4_bp_m_valid_%0d", i), 32'(bus.m_valid), 32'd1);
         chk($sformatf("t4_bp_m_result_%0d", i), bus.m_result, 32'd1);
         chk($sformatf("t4_bp_m_tag_%0d", i), 32'(bus.m_tag), 32'd12);
         chk($sformatf("t4_bp_m_src_%0d", i), 32'(bus.m_src), 32'd0);
         step();
      end
      bus.m_ready = 1'b1;
      #1;
      chk("t4_release_s0_ready", 32'(bus.s0_ready), 32'd1);
      push(32'd0, 1'b0, 5'd13);
      step();
      drv(0, 0, 0, 0, 7'd0, 3'd0, 5'd0);
      chk("t4_refill_m_valid", 32'(bus.m_valid), 32'd1);
      chk("t4_refill_m_tag", 32'(bus.m_tag), 32'd13);
      chk("t4_conflict_cnt_held", 32'(bus.conflict_cnt), 32'd4);

      // Unsupported encodings are accepted and return 0
      drv(0, 1, 32'd3, 32'd9, OP_R, F_ADD, 5'd14);
      #1;
      chk("t5_add_s0_ready", 32'(bus.s0_ready), 32'd1);
      push(32'd0, 1'b0, 5'd14);
      step();
      drv(0, 0, 0, 0, 7'd0, 3'd0, 5'd0);
      drv(1, 1, 32'd0, 32'd1, OP_LUI, F_SLT, 5'd15);
      #1;
      chk("t5_lui_s1_ready", 32'(bus.s1_ready), 32'd1);
      push(32'd0, 1'b1, 5'd15);
      step();
      drv(1, 0, 0, 0, 7'd0, 3'd0, 5'd0);
      step();

      // Async reset with a stalled result in the output stage; rr_ptr is 1 before reset
      bus.m_ready = 1'b0;
      drv(0, 1, 32'd0, 32'd1, OP_R, F_SLT, 5'd16);
      step();
      drv(0, 0, 0, 0, 7'd0, 3'd0, 5'd0);
      chk("t6_pre_m_valid", 32'(bus.m_valid), 32'd1);
      chk("t6_pre_queue_empty", 32'(exp_q.size()), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_m_valid", 32'(bus.m_valid), 32'd0);
      chk("t6_async_conflict_cnt", 32'(bus.conflict_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.m_ready = 1'b1;
      drv(0, 1, 32'd1, 32'd2, OP_R, F_SLTU, 5'd17);
      drv(1, 1, 32'd2, 32'd1, OP_R, F_SLT, 5'd18);
      #1;
      chk("t6_post_s0_ready", 32'(bus.s0_ready), 32'd1);
      chk("t6_post_s1_ready", 32'(bus.s1_ready), 32'd0);
      push(32'd1, 1'b0, 5'd17);
      step();
      chk("t6_post_s1_ready_2nd", 32'(bus.s1_ready), 32'd1);
      push(32'd0, 1'b1, 5'd18);
      step();
      drv(0, 0, 0, 0, 7'd0, 3'd0, 5'd0);
      drv(1, 0, 0, 0, 7'd0, 3'd0, 5'd0);
      chk("t6_conflict_cnt", 32'(bus.conflict_cnt), 32'd2);

      repeat (3) step();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cmp_share_arbiter.md
# cmp_share_arbiter

Two-requester arbiter and one-stage pipeline that shares a single set-less-than compare datapath (SLT/SLTI signed, SLTU/SLTIU unsigned) in the execute stage. The main integer pipe is requester 0 and the branch/address helper is requester 1. The block grants one request per cycle round-robin, computes the compare result, and returns it from a registered output stage with valid/ready backpressure, tagged with source and destination tag.

## Interface
Parameters:
- DATA_W, 32, operand and result width
- TAG_W, 5, requester tag width (destination register index)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- s0_valid  input  1  requester 0 has a compare request
- s0_ready  output  1  requester 0 request accepted this cycle
- s0_op1, s0_op2  input  DATA_W  rs1 and rs2-or-immediate (immediate already selected)
- s0_opcode  input  7  instruction[6:0]
- s0_func3  input  3  instruction[14:12]
- s0_tag  input  TAG_W  returned unchanged with the result
- s1_*  same set as s0_*, for requester 1
- m_valid  output  1  registered result available
- m_ready  input  1  consumer takes the result
- m_result  output  DATA_W  compare result, 0 or 1
- m_src  output  1  source of the result (0 or 1)
- m_tag  output  TAG_W  tag of the granted request
- conflict_cnt  output  16  saturating count of contested accepts

## Operation
- Accept condition: `can_issue = !m_valid || m_ready`.
- Grant rules, evaluated only when can_issue = 1:
  - Only one s*_valid high: grant that requester.
  - Both high: grant the requester selected by rr_ptr.
  - Neither high: no grant.
- Handshake:
  - s0_ready = can_issue && grant==0; s1_ready = can_issue && grant==1.
  - Ready is combinational and asserts only for the granted requester.
  - A request transfers on valid && ready.
- rr_ptr:
  - 1 bit; reset value 0.
  - After every grant it updates to the non-granted index (1 - grant).
  - Held when there is no grant.
- Result function, computed on the granted operands:
  - func3=010 with opcode 0110011 or 0010011: ($signed(op1) < $signed(op2)) ? 1 : 0.
  - func3=011 with the same opcodes: unsigned op1 < op2 ? 1 : 0.
  - Any other func3/opcode combination: 0. The request is still accepted and returned.
  - Result is zero-extended to DATA_W.
- Output register:
  - On a transfer: load m_result, m_src, m_tag; set m_valid = 1.
  - Else if m_ready: clear m_valid. m_result, m_src and m_tag hold their last values.
  - While m_valid && !m_ready, all m_* outputs are held stable.
- conflict_cnt: increments by 1 on each cycle where s0_valid && s1_valid && can_issue. Saturates at 16'hFFFF.
- Requesters must hold their payload stable while valid && !ready. The block does not check this.

## Timing
- Reset values: m_valid 0, m_result 0, m_src 0, m_tag 0, conflict_cnt 0, rr_ptr 0.
- Reset is asynchronous assert and synchronous-to-clk deassert; the synchronizer is provided externally.
- Latency: the request accepted in cycle N appears on m_* with m_valid=1 in cycle N+1.
- Throughput: one result per cycle while m_ready=1. There are no bubbles between back-to-back grants.
- Backpressure: m_valid=1 and m_ready=0 forces both s*_ready=0. rr_ptr and conflict_cnt are unchanged that cycle.
- Same-cycle drain and refill: m_valid=1, m_ready=1 and a pending request gives a new grant in the same cycle. m_valid stays 1 with new contents.
- Reset mid-operation: any in-flight result is discarded, m_valid drops immediately, and rr_ptr returns to 0.
- No combinational path from s*_op* to m_*. The only combinational paths are s*_valid and m_ready to s*_ready.

## Test plan
- Single request: s0 only, SLT, op1=32'hFFFF_FFFF, op2=1, tag=7. Required: s0_ready=1 in cycle 0; cycle 1 gives m_valid=1, m_result=1, m_src=0, m_tag=7.
- Signed vs unsigned on the same operands: s1 SLTU (opcode 0110011, func3 011), op1=32'hFFFF_FFFF, op2=1. Required: m_result=0, m_src=1. Then SLTIU (opcode 0010011) with op1=0, op2=5. Required: m_result=1.
- Contention, round-robin: s0 and s1 both valid for 4 cycles, m_ready=1. Required grant order is 0,1,0,1; conflict_cnt=4; m_src sequence 0,1,0,1 starting one cycle later.
- Backpressure: m_valid=1, m_ready=0 for 3 cycles with s0 valid. Required: s0_ready=0 and m_* stable across all 3 cycles. Then m_ready=1: s0 granted that same cycle and the new result appears the next cycle.
- Unsupported op: opcode 0110011, func3 000 (ADD), op1=3, op2=9. Required: accepted, m_result=0.
- Async reset mid-operation: assert rst_n=0 between clock edges while m_valid=1. Required: m_valid=0 and conflict_cnt=0 immediately. After release with both requesters valid, requester 0 is granted first.
